muldiv_sched: RTL and testbench
===============================

Name: muldiv_sched

Overview:
- Front-end controller for the M-extension datapath. Accepts one multiply or divide op at a time from the execute stage and issues it to the shared multiply unit or to the divide unit.
- Captures the unit's result into a holding register. Presents the result, tagged with rd, to writeback through a valid/ready handshake.
- Drives flush to both units and exports busy/rd status for hazard detection.
- Also keeps per-class completion counters for performance monitoring.

Parameters:
CNT_W, 32, width of the completed-op counters mul_cnt_o / div_cnt_o (wrap on overflow).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
m_valid_i  in  1  op offered by execute
m_ready_o  out  1  scheduler can accept op
m_is_div_i  in  1  0: route to multiply unit, 1: route to divide unit
m_func_i  in  4  function code (cpu_consts encoding), passed through unchanged
word_op_i  in  1  RV64 W-variant
opr_a_i  in  64  operand A
opr_b_i  in  64  operand B
rd_i  in  5  destination register
flush_i  in  1  pipeline flush
mul_valid_o / div_valid_o  out  1  issue request to unit
mul_ready_i / div_ready_i  in  1  unit accepts op
unit_func_o  out  4  registered func to both units
unit_word_o  out  1  registered word_op to both units
unit_opr_a_o / unit_opr_b_o  out  64  registered operands to both units
mul_res_valid_i / div_res_valid_i  in  1  unit result valid
mul_res_i / div_res_i  in  64  unit result
mul_res_ready_o / div_res_ready_o  out  1  scheduler takes result
unit_flush_o  out  1  flush to both units
wb_valid_o  out  1  result to writeback valid
wb_ready_i  in  1  writeback accepts
wb_rd_o  out  5  result destination
wb_data_o  out  64  result data
busy_o  out  1  op in flight (any state except IDLE)
busy_rd_o  out  5  rd of in-flight op (0 when idle)
mul_cnt_o / div_cnt_o  out  CNT_W  completed (written-back) ops per class

Behaviour:
- Clocking and reset: one clock, reset asynchronous active-low; clk and resetn are the port names.
- Reset values: state=IDLE, all registers 0, wb_valid_o=0, mul_valid_o=div_valid_o=0, counters 0, busy_o=0, busy_rd_o=0. m_ready_o=0 while resetn is low, and 1 from the first cycle after release.
- State IDLE:
  - m_ready_o=1.
  - On m_valid_i & ~flush_i: register func, word, operands, rd and is_div; go to ISSUE.
- State ISSUE:
  - Assert mul_valid_o (is_div=0) or div_valid_o (is_div=1), never both, holding all unit_* outputs stable.
  - When the selected ready_i=1: go to WAIT at the end of that cycle.
  - If ready is low, keep requesting indefinitely.
- State WAIT:
  - Selected res_ready_o=1.
  - On the selected res_valid_i: capture res into wb_data, go to WB.
  - The res_valid_i of the non-selected unit is ignored.
- State WB:
  - wb_valid_o=1; wb_rd_o and wb_data_o held stable.
  - On wb_ready_i: increment the matching counter, go to IDLE. m_ready_o is 1 only on the following cycle; there is no same-cycle accept.
- Flush:
  - unit_flush_o = flush_i, combinational.
  - In any state, flush_i forces IDLE next cycle and discards the buffered op/result.
  - During a flush cycle, wb_valid_o, mul_valid_o, div_valid_o, mul_res_ready_o and div_res_ready_o are all 0. No counter increments.
  - m_valid_i during flush is not accepted.
- Flush vs. handshake: flush in WB with wb_ready_i=1 in the same cycle means flush wins and there is no writeback.
- Latency with mul_ready_i=1 immediately (accept at cycle T):
  - 64-bit multiply: wb_valid_o rises at T+6.
  - Word multiply: wb_valid_o rises at T+4.
  - Divide: unit latency + 3.
- busy_o=1 in ISSUE/WAIT/WB; busy_rd_o=registered rd in those states.
- Counters wrap modulo 2^CNT_W.

Test Plan:
- MUL 6×7, rd=5, accept at T -> mul_valid_o at T+1; wb_valid_o at T+6 with wb_data_o=0x2A, wb_rd_o=5; mul_cnt_o=1 after the handshake.
- MULW 0xFFFFFFFF × 2 (word) -> wb_data_o=0xFFFFFFFFFFFFFFFE at T+4; div_valid_o never asserted.
- DIV op (m_is_div_i=1) with div_ready_i held low 4 cycles -> div_valid_o held 5 cycles with operands stable; mul_valid_o stays 0; result from the div model is written back and div_cnt_o increments.
- Result in WB with wb_ready_i low for 3 cycles -> wb_valid_o, wb_rd_o and wb_data_o stable; m_ready_o=0 throughout; accept takes effect on the 4th cycle.
- flush_i pulsed in WAIT -> unit_flush_o=1 that cycle, IDLE next, no wb_valid_o, counters unchanged. A late mul_res_valid_i arriving in IDLE is ignored.
- resetn asserted mid-op in ISSUE -> all outputs at reset values immediately; after release, a new MUL 3×3 completes with wb_data_o=9.

Source files
------------

// File: rtl/muldiv_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_sched : issues one M-extension op to the mul or div unit, buffers  |
// | the result for writeback and counts completions per class. Rev 1.0        |
// +--------------------------------------------------------------------------+
module muldiv_sched #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             m_valid_i,
    output logic             m_ready_o,
    input  logic             m_is_div_i,
    input  logic [3:0]       m_func_i,
    input  logic             word_op_i,
    input  logic [63:0]      opr_a_i,
    input  logic [63:0]      opr_b_i,
    input  logic [4:0]       rd_i,
    input  logic             flush_i,
    output logic             mul_valid_o,
    output logic             div_valid_o,
    input  logic             mul_ready_i,
    input  logic             div_ready_i,
    output logic [3:0]       unit_func_o,
    output logic             unit_word_o,
    output logic [63:0]      unit_opr_a_o,
    output logic [63:0]      unit_opr_b_o,
    input  logic             mul_res_valid_i,
    input  logic             div_res_valid_i,
    input  logic [63:0]      mul_res_i,
    input  logic [63:0]      div_res_i,
    output logic             mul_res_ready_o,
    output logic             div_res_ready_o,
    output logic             unit_flush_o,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [4:0]       wb_rd_o,
    output logic [63:0]      wb_data_o,
    output logic             busy_o,
    output logic [4:0]       busy_rd_o,
    output logic [CNT_W-1:0] mul_cnt_o,
    output logic [CNT_W-1:0] div_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              alive_q;
    logic [3:0]        func_q, func_d;
    logic              word_q, word_d;
    logic [63:0]       opr_a_q, opr_a_d;
    logic [63:0]       opr_b_q, opr_b_d;
    logic [4:0]        rd_q, rd_d;
    logic              is_div_q, is_div_d;
    logic [63:0]       wb_data_q, wb_data_d;
    logic [CNT_W-1:0]  mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;

    always_comb begin
        state_d         = state_q;
        func_d          = func_q;
        word_d          = word_q;
        opr_a_d         = opr_a_q;
        opr_b_d         = opr_b_q;
        rd_d            = rd_q;
        is_div_d        = is_div_q;
        wb_data_d       = wb_data_q;
        mul_cnt_d       = mul_cnt_q;
        div_cnt_d       = div_cnt_q;
        m_ready_o       = 1'b0;
        mul_valid_o     = 1'b0;
        div_valid_o     = 1'b0;
        mul_res_ready_o = 1'b0;
        div_res_ready_o = 1'b0;
        wb_valid_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // alive_q keeps ready low until the first edge after reset release
                m_ready_o = alive_q;
                if (alive_q && m_valid_i && !flush_i) begin
                    func_d   = m_func_i;
                    word_d   = word_op_i;
                    opr_a_d  = opr_a_i;
                    opr_b_d  = opr_b_i;
                    rd_d     = rd_i;
                    is_div_d = m_is_div_i;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_valid_o = !is_div_q;
                div_valid_o = is_div_q;
                if (is_div_q ? div_ready_i : mul_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                mul_res_ready_o = !is_div_q;
                div_res_ready_o = is_div_q;
                if (is_div_q ? div_res_valid_i : mul_res_valid_i) begin
                    wb_data_d = is_div_q ? div_res_i : mul_res_i;
                    state_d   = S_WB;
                end
            end
            S_WB: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    if (is_div_q) begin
                        div_cnt_d = div_cnt_q + C_CNT_ONE;
                    end else begin
                        mul_cnt_d = mul_cnt_q + C_CNT_ONE;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides every handshake and leaves the counters untouched
        if (flush_i) begin
            state_d         = S_IDLE;
            mul_valid_o     = 1'b0;
            div_valid_o     = 1'b0;
            mul_res_ready_o = 1'b0;
            div_res_ready_o = 1'b0;
            wb_valid_o      = 1'b0;
            mul_cnt_d       = mul_cnt_q;
            div_cnt_d       = div_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            alive_q   <= 1'b0;
            func_q    <= '0;
            word_q    <= 1'b0;
            opr_a_q   <= '0;
            opr_b_q   <= '0;
            rd_q      <= '0;
            is_div_q  <= 1'b0;
            wb_data_q <= '0;
            mul_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            alive_q   <= 1'b1;
            func_q    <= func_d;
            word_q    <= word_d;
            opr_a_q   <= opr_a_d;
            opr_b_q   <= opr_b_d;
            rd_q      <= rd_d;
            is_div_q  <= is_div_d;
            wb_data_q <= wb_data_d;
            mul_cnt_q <= mul_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign unit_func_o  = func_q;
    assign unit_word_o  = word_q;
    assign unit_opr_a_o = opr_a_q;
    assign unit_opr_b_o = opr_b_q;
    assign unit_flush_o = flush_i;
    assign wb_rd_o      = rd_q;
    assign wb_data_o    = wb_data_q;
    assign busy_o       = (state_q != S_IDLE);
    assign busy_rd_o    = busy_o ? rd_q : 5'd0;
    assign mul_cnt_o    = mul_cnt_q;
    assign div_cnt_o    = div_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_sched : directed bench for muldiv_sched with small unit models. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m_valid_i = 1'b0;
    logic        m_ready_o;
    logic        m_is_div_i = 1'b0;
    logic [3:0]  m_func_i = 4'h0;
    logic        word_op_i = 1'b0;
    logic [63:0] opr_a_i = '0;
    logic [63:0] opr_b_i = '0;
    logic [4:0]  rd_i = '0;
    logic        flush_i = 1'b0;
    logic        mul_valid_o, div_valid_o;
    logic        mul_ready_i = 1'b1;
    logic        div_ready_i = 1'b1;
    logic [3:0]  unit_func_o;
    logic        unit_word_o;
    logic [63:0] unit_opr_a_o, unit_opr_b_o;
    logic        mul_res_valid_i, div_res_valid_i;
    logic [63:0] mul_res_i, div_res_i;
    logic        mul_res_ready_o, div_res_ready_o;
    logic        unit_flush_o;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o;
    logic        busy_o;
    logic [4:0]  busy_rd_o;
    logic [31:0] mul_cnt_o, div_cnt_o;

    int n_pass  = 0;
    int n_total = 0;
    int mul_vcount = 0;
    int div_vcount = 0;
    int snap_mul, snap_div;
    logic force_mrv = 1'b0;

    always #5 clk = ~clk;

    muldiv_sched #(.CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid_i(m_valid_i), .m_ready_o(m_ready_o), .m_is_div_i(m_is_div_i),
        .m_func_i(m_func_i), .word_op_i(word_op_i),
        .opr_a_i(opr_a_i), .opr_b_i(opr_b_i), .rd_i(rd_i), .flush_i(flush_i),
        .mul_valid_o(mul_valid_o), .div_valid_o(div_valid_o),
        .mul_ready_i(mul_ready_i), .div_ready_i(div_ready_i),
        .unit_func_o(unit_func_o), .unit_word_o(unit_word_o),
        .unit_opr_a_o(unit_opr_a_o), .unit_opr_b_o(unit_opr_b_o),
        .mul_res_valid_i(mul_res_valid_i), .div_res_valid_i(div_res_valid_i),
        .mul_res_i(mul_res_i), .div_res_i(div_res_i),
        .mul_res_ready_o(mul_res_ready_o), .div_res_ready_o(div_res_ready_o),
        .unit_flush_o(unit_flush_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o), .busy_rd_o(busy_rd_o),
        .mul_cnt_o(mul_cnt_o), .div_cnt_o(div_cnt_o)
    );

    // Multiply unit: result 4 cycles after accept (2 for word ops)
    logic [2:0]  m_cnt;
    logic        m_pend;
    logic [63:0] m_res;
    logic [31:0] m_low;
    assign m_low = unit_opr_a_o[31:0] * unit_opr_b_o[31:0];
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pend <= 1'b0; m_cnt <= '0; m_res <= '0;
        end else if (unit_flush_o) begin
            m_pend <= 1'b0;
        end else if (mul_valid_o && mul_ready_i) begin
            m_pend <= 1'b1;
            m_cnt  <= unit_word_o ? 3'd1 : 3'd3;
            m_res  <= unit_word_o ? {{32{m_low[31]}}, m_low} : unit_opr_a_o * unit_opr_b_o;
        end else if (m_pend) begin
            if (m_cnt != 3'd0) m_cnt <= m_cnt - 3'd1;
            else if (mul_res_ready_o) m_pend <= 1'b0;
        end
    end
    assign mul_res_valid_i = (m_pend && m_cnt == 3'd0) || force_mrv;
    assign mul_res_i       = m_res;

    // Divide unit: unsigned quotient 3 cycles after accept
    logic [2:0]  d_cnt;
    logic        d_pend;
    logic [63:0] d_res;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_pend <= 1'b0; d_cnt <= '0; d_res <= '0;
        end else if (unit_flush_o) begin
            d_pend <= 1'b0;
        end else if (div_valid_o && div_ready_i) begin
            d_pend <= 1'b1;
            d_cnt  <= 3'd2;
            d_res  <= unit_opr_a_o / unit_opr_b_o;
        end else if (d_pend) begin
            if (d_cnt != 3'd0) d_cnt <= d_cnt - 3'd1;
            else if (div_res_ready_o) d_pend <= 1'b0;
        end
    end
    assign div_res_valid_i = d_pend && d_cnt == 3'd0;
    assign div_res_i       = d_res;

    always @(posedge clk) begin
        if (mul_valid_o) mul_vcount <= mul_vcount + 1;
        if (div_valid_o) div_vcount <= div_vcount + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_wb(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (wb_valid_o) break;
            @(negedge clk);
        end
        chk("wb_timeout", {63'd0, wb_valid_o}, 64'd1);
    endtask

    task automatic offer(input logic is_div, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        m_valid_i = 1'b1; m_is_div_i = is_div; word_op_i = word;
        opr_a_i = a; opr_b_i = b; rd_i = rd; m_func_i = 4'h3;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_m_ready", {63'd0, m_ready_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_wb_valid", {63'd0, wb_valid_o}, 64'd0);
        chk("rst_mul_valid", {63'd0, mul_valid_o}, 64'd0);
        chk("rst_cnt", {mul_cnt_o, div_cnt_o}, 64'd0);
        resetn = 1'b1;
        #1 chk("rel_m_ready_early", {63'd0, m_ready_o}, 64'd0);
        @(negedge clk);
        chk("rel_m_ready", {63'd0, m_ready_o}, 64'd1);

        // MUL 6x7 rd=5, accepted at T
        offer(1'b0, 1'b0, 64'd6, 64'd7, 5'd5);
        @(negedge clk);  // T+1
        m_valid_i = 1'b0;
        chk("mul_valid", {63'd0, mul_valid_o}, 64'd1);
        chk("mul_no_div", {63'd0, div_valid_o}, 64'd0);
        chk("mul_busy_rd", {59'd0, busy_rd_o}, 64'd5);
        chk("mul_func", {60'd0, unit_func_o}, 64'd3);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            chk("mul_wb_early", {63'd0, wb_valid_o}, 64'd0);
        end
        @(negedge clk);  // T+6
        chk("mul_wb_valid", {63'd0, wb_valid_o}, 64'd1);
        chk("mul_wb_data", wb_data_o, 64'h2A);
        chk("mul_wb_rd", {59'd0, wb_rd_o}, 64'd5);
        wb_ready_i = 1'b1;
        @(negedge clk);
        wb_ready_i = 1'b0;
        chk("mul_cnt", {32'd0, mul_cnt_o}, 64'd1);
        chk("mul_idle_ready", {63'd0, m_ready_o}, 64'd1);
        chk("mul_idle_wb", {63'd0, wb_valid_o}, 64'd0);

        // MULW 0xFFFFFFFF x 2 rd=7
        snap_div = div_vcount;
        offer(1'b0, 1'b1, 64'hFFFF_FFFF, 64'd2, 5'd7);
        @(negedge clk);  // T+1
        m_valid_i = 1'b0;
        chk("mulw_word", {63'd0, unit_word_o}, 64'd1);
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk);
            chk("mulw_wb_early", {63'd0, wb_valid_o}, 64'd0);
        end
        @(negedge clk);  // T+4
        chk("mulw_wb_valid", {63'd0, wb_valid_o}, 64'd1);
        chk("mulw_wb_data", wb_data_o, 64'hFFFF_FFFF_FFFF_FFFE);
        wb_ready_i = 1'b1;
        @(negedge clk);
        wb_ready_i = 1'b0;
        chk("mulw_no_div", div_vcount - snap_div, 64'd0);
        chk("mulw_cnt", {32'd0, mul_cnt_o}, 64'd2);

        // DIV 100/7 rd=12 with div_ready low for 4 cycles
        snap_mul = mul_vcount;
        snap_div = div_vcount;
        div_ready_i = 1'b0;
        offer(1'b1, 1'b0, 64'd100, 64'd7, 5'd12);
        @(negedge clk);  // D+1
        m_valid_i = 1'b0;
        opr_a_i = 64'hDEAD; opr_b_i = 64'hBEEF;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk);
            chk("div_valid", {63'd0, div_valid_o}, 64'd1);
            chk("div_opr_a", unit_opr_a_o, 64'd100);
            chk("div_opr_b", unit_opr_b_o, 64'd7);
        end
        div_ready_i = 1'b1;
        @(negedge clk);
        wait_wb(12);
        chk("div_vcount", div_vcount - snap_div, 64'd5);
        chk("div_no_mul", mul_vcount - snap_mul, 64'd0);
        for (int i = 1; i <= 3; i++) begin
            chk("stall_wb_valid", {63'd0, wb_valid_o}, 64'd1);
            chk("stall_wb_data", wb_data_o, 64'd14);
            chk("stall_wb_rd", {59'd0, wb_rd_o}, 64'd12);
            chk("stall_m_ready", {63'd0, m_ready_o}, 64'd0);
            @(negedge clk);
        end
        chk("stall4_wb_valid", {63'd0, wb_valid_o}, 64'd1);
        wb_ready_i = 1'b1;
        @(negedge clk);
        wb_ready_i = 1'b0;
        chk("div_cnt", {32'd0, div_cnt_o}, 64'd1);
        chk("div_mul_cnt", {32'd0, mul_cnt_o}, 64'd2);
        chk("div_idle", {63'd0, busy_o}, 64'd0);

        // Flush in WAIT, then a stray mul result while idle
        offer(1'b0, 1'b0, 64'd2, 64'd3, 5'd9);
        @(negedge clk);  // T+1
        m_valid_i = 1'b0;
        @(negedge clk);  // T+2, WAIT
        chk("fl_res_ready", {63'd0, mul_res_ready_o}, 64'd1);
        @(negedge clk);  // T+3
        flush_i = 1'b1;
        #1;
        chk("fl_unit_flush", {63'd0, unit_flush_o}, 64'd1);
        chk("fl_res_ready_low", {63'd0, mul_res_ready_o}, 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        chk("fl_idle", {63'd0, busy_o}, 64'd0);
        chk("fl_busy_rd", {59'd0, busy_rd_o}, 64'd0);
        force_mrv = 1'b1;
        #1 chk("fl_stray_ready", {63'd0, mul_res_ready_o}, 64'd0);
        @(negedge clk);
        force_mrv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fl_no_wb", {62'd0, wb_valid_o, busy_o}, 64'd0);
            @(negedge clk);
        end
        chk("fl_cnt", {mul_cnt_o, div_cnt_o}, {32'd2, 32'd1});

        // Reset mid-op in ISSUE, then MUL 3x3
        mul_ready_i = 1'b0;
        offer(1'b0, 1'b0, 64'd4, 64'd5, 5'd3);
        @(negedge clk);
        m_valid_i = 1'b0;
        chk("rs_issue", {63'd0, mul_valid_o}, 64'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rs_mul_valid", {63'd0, mul_valid_o}, 64'd0);
        chk("rs_busy", {58'd0, busy_o, busy_rd_o}, 64'd0);
        chk("rs_m_ready", {63'd0, m_ready_o}, 64'd0);
        chk("rs_cnt", {mul_cnt_o, div_cnt_o}, 64'd0);
        chk("rs_opr", unit_opr_a_o, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        mul_ready_i = 1'b1;
        @(negedge clk);
        chk("rs_rel_ready", {63'd0, m_ready_o}, 64'd1);
        offer(1'b0, 1'b0, 64'd3, 64'd3, 5'd1);
        @(negedge clk);
        m_valid_i = 1'b0;
        wait_wb(10);
        chk("rs_wb_data", wb_data_o, 64'd9);
        chk("rs_wb_rd", {59'd0, wb_rd_o}, 64'd1);
        wb_ready_i = 1'b1;
        @(negedge clk);
        wb_ready_i = 1'b0;
        chk("rs_mul_cnt", {32'd0, mul_cnt_o}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
